// File: rtl/div_clk_monitor.sv
// div_clk_monitor: checks three even-divided clocks (div2, div4, div10) against
// their expected periods, all treated as data launched from clk.
//   clk, rstn          : single clock, asynchronous active-low reset
//   clk_div2/4/10      : divided-clock inputs, channels 0/1/2
//   err_clr            : synchronous pulse clearing the sticky error flags
//   locked             : every channel has seen LOCK_CNT consecutive good periods
//   err[2:0]           : sticky per-channel fault flags (wrong period or timeout)
//   meas_div10[CW-1:0] : last measured clk_div10 period in clk cycles
module div_clk_monitor #(
    parameter int unsigned P2       = 2,
    parameter int unsigned P4       = 4,
    parameter int unsigned P10      = 10,
    parameter int unsigned LOCK_CNT = 4,
    parameter int unsigned CW       = 8
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          clk_div2,
    input  logic          clk_div4,
    input  logic          clk_div10,
    input  logic          err_clr,
    output logic          locked,
    output logic [2:0]    err,
    output logic [CW-1:0] meas_div10
);
    localparam int unsigned NCH = 3;
    localparam int unsigned GW  = $clog2(LOCK_CNT + 1);

    typedef enum logic {ACQ = 1'b0, MEAS = 1'b1} state_e;

    logic [NCH-1:0]         div_in;
    logic [NCH-1:0]         s_q;
    logic [NCH-1:0]         prev_q;
    logic [NCH-1:0]         rise;
    logic [NCH-1:0]         err_ev;
    logic [NCH-1:0]         good_full;
    logic [NCH-1:0]         meas_ld;
    logic [NCH-1:0][CW-1:0] cnt_all;
    logic [NCH-1:0]         err_q;
    logic [NCH-1:0]         err_d;
    logic [CW-1:0]          meas_q;
    logic [CW-1:0]          meas_d;

    assign div_in = {clk_div10, clk_div4, clk_div2};
    assign rise   = s_q & ~prev_q;

    // Sample and previous-sample registers for rising-edge detection.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            s_q    <= '0;
            prev_q <= '0;
        end else begin
            s_q    <= div_in;
            prev_q <= s_q;
        end
    end

    for (genvar g = 0; g < NCH; g++) begin : g_ch
        localparam int unsigned   PI  = (g == 0) ? P2 : ((g == 1) ? P4 : P10);
        localparam logic [CW-1:0] PER = CW'(PI);
        localparam logic [CW-1:0] TMO = CW'(2 * PI);

        state_e         state_q;
        state_e         state_d;
        logic [CW-1:0]  cnt_q;
        logic [CW-1:0]  cnt_d;
        logic [GW-1:0]  good_q;
        logic [GW-1:0]  good_d;
        logic           ev;
        logic           ld;

        // Per-channel period measurement; a rise wins over a same-cycle timeout.
        always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            good_d  = good_q;
            ev      = 1'b0;
            ld      = 1'b0;
            case (state_q)
                ACQ: begin
                    cnt_d = '0;
                    if (rise[g]) begin
                        state_d = MEAS;
                        cnt_d   = CW'(1);
                    end
                end
                MEAS: begin
                    if (rise[g]) begin
                        ld    = 1'b1;
                        cnt_d = CW'(1);
                        if (cnt_q == PER) begin
                            good_d = (good_q == GW'(LOCK_CNT)) ? good_q : good_q + GW'(1);
                        end else begin
                            good_d = '0;
                            ev     = 1'b1;
                        end
                    end else if (cnt_q == TMO) begin
                        ev      = 1'b1;
                        good_d  = '0;
                        cnt_d   = '0;
                        state_d = ACQ;
                    end else if (cnt_q != '1) begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                default: begin
                    state_d = ACQ;
                    cnt_d   = '0;
                end
            endcase
        end

        always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
                state_q <= ACQ;
                cnt_q   <= '0;
                good_q  <= '0;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
                good_q  <= good_d;
            end
        end

        assign err_ev[g]    = ev;
        assign meas_ld[g]   = ld;
        assign cnt_all[g]   = cnt_q;
        assign good_full[g] = (good_q == GW'(LOCK_CNT));
    end

    // Error set dominates a coincident clear.
    always_comb begin
        err_d  = (err_q & ~{NCH{err_clr}}) | err_ev;
        meas_d = meas_ld[2] ? cnt_all[2] : meas_q;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            err_q  <= '0;
            meas_q <= '0;
        end else begin
            err_q  <= err_d;
            meas_q <= meas_d;
        end
    end

    assign locked     = &good_full;
    assign err        = err_q;
    assign meas_div10 = meas_q;
endmodule

// File: tb/tb_div_clk_monitor.sv
// Bench for div_clk_monitor: divided-clock generators with stretch/stuck knobs,
// a reference model working on absolute edge numbers of observed rises.
module tb_div_clk_monitor;
    logic       clk = 1'b0;
    logic       rstn = 1'b1;
    logic       clk_div2 = 1'b0;
    logic       clk_div4 = 1'b0;
    logic       clk_div10 = 1'b0;
    logic       err_clr = 1'b0;
    logic       locked;
    logic [2:0] err;
    logic [7:0] meas_div10;

    div_clk_monitor dut (
        .clk        (clk),
        .rstn       (rstn),
        .clk_div2   (clk_div2),
        .clk_div4   (clk_div4),
        .clk_div10  (clk_div10),
        .err_clr    (err_clr),
        .locked     (locked),
        .err        (err),
        .meas_div10 (meas_div10)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int edge_n  = 0;

    // generator state
    int per[3] = '{2, 4, 10};
    int ph[3];
    int hi_cur[3];
    int stuck[3];
    bit stretch[3];
    bit late_next[3];
    bit was_stuck[3];
    int late_edge[3];
    int resume_edge[3];
    bit cur[3];
    bit clr_req = 1'b0;
    bit clr_on_late0 = 1'b0;
    int clr_edge = -100;

    // model state
    bit         m_acq[3];
    int         m_last[3];
    int         m_good[3];
    logic [2:0] m_err;
    int         m_meas;
    logic       m_locked;
    bit         v1[3];
    bit         v2[3];

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            m_acq[i] = 1'b1; m_last[i] = 0; m_good[i] = 0; v1[i] = 1'b0; v2[i] = 1'b0;
        end
        m_err = 3'b000; m_meas = 0; m_locked = 1'b0;
    endtask

    // One clk edge as seen by the specification: a rise is visible two edges after launch.
    task automatic model_edge();
        bit ev[3];
        bit r;
        int el;
        if (!rstn) begin
            model_reset();
            return;
        end
        for (int i = 0; i < 3; i++) begin
            ev[i] = 1'b0;
            r = v1[i] && !v2[i];
            if (m_acq[i]) begin
                if (r) begin m_acq[i] = 1'b0; m_last[i] = edge_n; end
            end else begin
                el = edge_n - m_last[i];
                if (r) begin
                    if (el == per[i]) m_good[i] = (m_good[i] < 4) ? m_good[i] + 1 : 4;
                    else begin m_good[i] = 0; ev[i] = 1'b1; end
                    if (i == 2) m_meas = el;
                    m_last[i] = edge_n;
                end else if (el == 2 * per[i]) begin
                    ev[i] = 1'b1; m_good[i] = 0; m_acq[i] = 1'b1;
                end
            end
        end
        m_err = (err_clr ? 3'b000 : m_err) | {ev[2], ev[1], ev[0]};
        for (int i = 0; i < 3; i++) begin v2[i] = v1[i]; v1[i] = cur[i]; end
        m_locked = (m_good[0] == 4) && (m_good[1] == 4) && (m_good[2] == 4);
    endtask

    task automatic gen_restart(input bit rnd);
        for (int i = 0; i < 3; i++) begin
            ph[i] = rnd ? int'($urandom_range(0, per[i] - 1)) : 0;
            hi_cur[i] = per[i] / 2; stuck[i] = 0; stretch[i] = 1'b0;
            late_next[i] = 1'b0; was_stuck[i] = 1'b0;
        end
    endtask

    task automatic drive_inputs();
        bit prevv;
        for (int i = 0; i < 3; i++) begin
            prevv = cur[i];
            if (stuck[i] > 0) begin
                stuck[i]--; cur[i] = 1'b0; ph[i] = 0; hi_cur[i] = per[i] / 2;
                was_stuck[i] = 1'b1; late_next[i] = 1'b0;
            end else begin
                cur[i] = (ph[i] < hi_cur[i]);
                ph[i]++;
                if (ph[i] == hi_cur[i] + per[i] / 2) begin
                    ph[i] = 0;
                    late_next[i] = (hi_cur[i] > per[i] / 2);
                    hi_cur[i] = per[i] / 2 + (stretch[i] ? 1 : 0);
                    stretch[i] = 1'b0;
                end
                if (cur[i] && !prevv) begin
                    if (late_next[i]) begin
                        late_next[i] = 1'b0; late_edge[i] = edge_n;
                        if (i == 0 && clr_on_late0) clr_edge = edge_n + 2;
                    end
                    if (was_stuck[i]) begin was_stuck[i] = 1'b0; resume_edge[i] = edge_n; end
                end
            end
        end
        clk_div2 = cur[0]; clk_div4 = cur[1]; clk_div10 = cur[2];
        err_clr = clr_req || (edge_n + 1 == clr_edge);
        clr_req = 1'b0;
    endtask

    // Launch inputs, take one clk edge, update the model, then sample 1 ns later.
    task automatic tick();
        drive_inputs();
        @(posedge clk);
        edge_n++;
        model_edge();
        #1;
    endtask

    task automatic test_reset();
        #1 rstn = 1'b0;
        #1;
        n_tests++;
        if ({locked, err, meas_div10} !== 12'h000) begin
            n_fail++;
            $display("FAIL reset_immediate got locked=%b err=%b meas=%0d exp 0/000/0", locked, err, meas_div10);
        end
        model_reset();
        gen_restart(1'b0);
        for (int k = 0; k < 8; k++) begin
            tick();
            n_tests++;
            if ({locked, err, meas_div10} !== 12'h000) begin
                n_fail++;
                $display("FAIL reset_hold edge=%0d got locked=%b err=%b meas=%0d exp 0/000/0", edge_n, locked, err, meas_div10);
            end
        end
    endtask

    task automatic test_nominal(input string tag);
        int rel;
        int first;
        rstn = 1'b1;
        gen_restart(1'b0);
        rel = edge_n;
        first = -1;
        for (int k = 0; k < 60; k++) begin
            tick();
            n_tests++;
            if ({locked, err, meas_div10} !== {m_locked, m_err, 8'(m_meas)}) begin
                n_fail++;
                $display("FAIL %s_cycle edge=%0d got %b/%b/%0d exp %b/%b/%0d", tag, edge_n,
                         locked, err, meas_div10, m_locked, m_err, m_meas);
            end
            if (locked === 1'b1 && first < 0) first = edge_n - rel;
        end
        n_tests++;
        if (first < 40 || first > 50) begin
            n_fail++;
            $display("FAIL %s_lock_time got %0d exp 40..50", tag, first);
        end
        n_tests++;
        if ({locked, err, meas_div10} !== {1'b1, 3'b000, 8'd10}) begin
            n_fail++;
            $display("FAIL %s_final got %b/%b/%0d exp 1/000/10", tag, locked, err, meas_div10);
        end
    endtask

    task automatic test_period_error();
        late_edge[1] = -100;
        stretch[1] = 1'b1;
        for (int k = 0; k < 60; k++) begin
            tick();
            n_tests++;
            if ({locked, err, meas_div10} !== {m_locked, m_err, 8'(m_meas)}) begin
                n_fail++;
                $display("FAIL period_err_cycle edge=%0d got %b/%b/%0d exp %b/%b/%0d", edge_n,
                         locked, err, meas_div10, m_locked, m_err, m_meas);
            end
            if (late_edge[1] >= 0 && edge_n == late_edge[1] + 1) begin
                n_tests++;
                if (locked !== 1'b1) begin
                    n_fail++;
                    $display("FAIL period_err_before got locked=%b exp 1", locked);
                end
            end
            if (late_edge[1] >= 0 && edge_n == late_edge[1] + 2) begin
                n_tests++;
                if ({locked, err} !== {1'b0, 3'b010}) begin
                    n_fail++;
                    $display("FAIL period_err_flag got locked=%b err=%b exp 0/010", locked, err);
                end
            end
        end
        n_tests++;
        if ({locked, err} !== {1'b1, 3'b010}) begin
            n_fail++;
            $display("FAIL period_err_relock got locked=%b err=%b exp 1/010", locked, err);
        end
    endtask

    task automatic test_stuck();
        int relock;
        resume_edge[2] = -100;
        stuck[2] = 25;
        for (int k = 0; k < 27; k++) begin
            tick();
            n_tests++;
            if ({locked, err, meas_div10} !== {m_locked, m_err, 8'(m_meas)}) begin
                n_fail++;
                $display("FAIL stuck_cycle edge=%0d got %b/%b/%0d exp %b/%b/%0d", edge_n,
                         locked, err, meas_div10, m_locked, m_err, m_meas);
            end
        end
        n_tests++;
        if ({locked, err[2]} !== 2'b01) begin
            n_fail++;
            $display("FAIL stuck_timeout got locked=%b err2=%b exp 0/1", locked, err[2]);
        end
        relock = -1;
        for (int k = 0; k < 60 && relock < 0; k++) begin
            tick();
            n_tests++;
            if ({locked, err, meas_div10} !== {m_locked, m_err, 8'(m_meas)}) begin
                n_fail++;
                $display("FAIL stuck_relock_cycle edge=%0d got %b/%b/%0d exp %b/%b/%0d", edge_n,
                         locked, err, meas_div10, m_locked, m_err, m_meas);
            end
            if (locked === 1'b1) relock = edge_n;
        end
        n_tests++;
        if (relock - resume_edge[2] != 42) begin
            n_fail++;
            $display("FAIL stuck_relock_time got %0d exp 42", relock - resume_edge[2]);
        end
        n_tests++;
        if (err !== 3'b110) begin
            n_fail++;
            $display("FAIL stuck_err got %b exp 110", err);
        end
    endtask

    task automatic test_err_clr();
        bit seen;
        clr_req = 1'b1;
        tick();
        n_tests++;
        if (err !== 3'b000) begin
            n_fail++;
            $display("FAIL err_clr_plain got %b exp 000", err);
        end
        late_edge[0] = -100;
        stretch[0] = 1'b1;
        clr_on_late0 = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            tick();
            n_tests++;
            if ({locked, err, meas_div10} !== {m_locked, m_err, 8'(m_meas)}) begin
                n_fail++;
                $display("FAIL err_clr_cycle edge=%0d got %b/%b/%0d exp %b/%b/%0d", edge_n,
                         locked, err, meas_div10, m_locked, m_err, m_meas);
            end
            if (late_edge[0] >= 0 && edge_n == late_edge[0] + 2) begin
                seen = 1'b1;
                n_tests++;
                if ({err_clr, err} !== {1'b1, 3'b001}) begin
                    n_fail++;
                    $display("FAIL err_clr_set_dominates got clr=%b err=%b exp 1/001", err_clr, err);
                end
            end
        end
        clr_on_late0 = 1'b0;
        n_tests++;
        if (!seen) begin
            n_fail++;
            $display("FAIL err_clr_window got no late rise exp one within 20 cycles");
        end
    endtask

    task automatic test_reset_mid_lock();
        for (int k = 0; k < 40 && locked !== 1'b1; k++) tick();
        n_tests++;
        if (locked !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_lock_pre got locked=%b exp 1", locked);
        end
        rstn = 1'b0;
        #1;
        n_tests++;
        if ({locked, err, meas_div10} !== 12'h000) begin
            n_fail++;
            $display("FAIL mid_reset_immediate got %b/%b/%0d exp 0/000/0", locked, err, meas_div10);
        end
        model_reset();
        for (int k = 0; k < 3; k++) begin
            tick();
            n_tests++;
            if ({locked, err, meas_div10} !== 12'h000) begin
                n_fail++;
                $display("FAIL mid_reset_hold got %b/%b/%0d exp 0/000/0", locked, err, meas_div10);
            end
        end
        test_nominal("relock");
    endtask

    task automatic test_random();
        int c;
        rstn = 1'b0;
        tick();
        tick();
        rstn = 1'b1;
        gen_restart(1'b1);
        for (int k = 0; k < 2500; k++) begin
            if ($urandom_range(0, 39) == 0) begin
                c = int'($urandom_range(0, 2)); stretch[c] = 1'b1;
            end
            if ($urandom_range(0, 299) == 0) begin
                c = int'($urandom_range(0, 2));
                if (stuck[c] == 0) stuck[c] = int'($urandom_range(3, 30));
            end
            if ($urandom_range(0, 59) == 0) clr_req = 1'b1;
            tick();
            n_tests++;
            if ({locked, err, meas_div10} !== {m_locked, m_err, 8'(m_meas)}) begin
                n_fail++;
                $display("FAIL random_cycle edge=%0d got %b/%b/%0d exp %b/%b/%0d", edge_n,
                         locked, err, meas_div10, m_locked, m_err, m_meas);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            cur[i] = 1'b0; late_edge[i] = -100; resume_edge[i] = -100;
        end
        model_reset();
        gen_restart(1'b0);
        test_reset();
        test_nominal("nominal");
        test_period_error();
        test_stuck();
        test_err_clr();
        test_reset_mid_lock();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/div_clk_monitor.md
DIV_CLK_MONITOR -- requirements
Module: div_clk_monitor

Interface
REQ-001 Parameters, one per line: name, default, meaning.
  P2        2   expected clk_div2 period, in clk cycles
  P4        4   expected clk_div4 period, in clk cycles
  P10       10  expected clk_div10 period, in clk cycles
  LOCK_CNT  4   consecutive correct periods per channel required for lock
  CW        8   width of the period counters and of meas_div10
REQ-002 Ports, one per line: name, direction, width, meaning.
  clk         in   1   single clock; all logic on the rising edge
  rstn        in   1   reset, asynchronous, active-low
  clk_div2    in   1   divided clock from the even divider (channel 0)
  clk_div4    in   1   divided clock from the even divider (channel 1)
  clk_div10   in   1   divided clock from the even divider (channel 2)
  err_clr     in   1   synchronous pulse; clears err
  locked      out  1   all three channels have verified frequency
  err         out  3   sticky per-channel fault flags; bit i = channel i
  meas_div10  out  CW  last measured clk_div10 period, in clk cycles
REQ-003 The block SHALL have one clock, clk; reset SHALL be asynchronous and active-low on rstn.

Function
REQ-004 The divided-clock inputs SHALL be treated as data generated from clk.
  - They change only after clk rising edges.
  - There are no synchronizers.
  - Each input SHALL pass through one sample register s; a second register holds prev.
  - rise = s AND NOT prev.
REQ-005 Each channel SHALL own an independent 2-state FSM (ACQ, MEAS), a CW-bit period counter cnt, and a good counter saturating at LOCK_CNT.
REQ-006 ACQ behaviour:
  - cnt held at 0.
  - On rise: go to MEAS, cnt <= 1.
REQ-007 MEAS behaviour:
  - Without rise: cnt increments by 1, saturating at all-ones.
  - On rise: the measured period is cnt.
  - Period equal to expected P: good increments, saturating at LOCK_CNT.
  - Period not equal to P: good <= 0 and err[i] <= 1.
  - Either way: cnt <= 1 and the FSM stays in MEAS.
REQ-008 Timeout: in MEAS, if cnt reaches 2*P with no rise, the channel SHALL do all of the following in that cycle:
  - set err[i];
  - clear good;
  - return to ACQ with cnt <= 0.
REQ-009 Latency: an input edge launched after clk edge k SHALL update channel state at clk edge k+2.
REQ-010 locked SHALL be the AND of (good == LOCK_CNT) over all three channels, decoded directly from registers with no extra delay.
REQ-011 locked SHALL deassert in the cycle after any channel records a wrong period or a timeout.
REQ-012 meas_div10 SHALL load cnt of channel 2 on every channel-2 rise in MEAS, whether the period is good or bad; otherwise it holds.
REQ-013 err bits SHALL be sticky. err_clr clears all bits. When err_clr coincides with an error event on channel i, err[i] SHALL be 1 (set dominates).
REQ-014 A simultaneous rise and timeout on the same channel SHALL be treated as a rise.

Reset
REQ-015 While rstn=0, all of the following SHALL hold immediately, independent of clk:
  - locked=0, err=3'b000, meas_div10=0;
  - every FSM in ACQ;
  - all cnt, good, s and prev registers = 0.
REQ-016 Reset asserted mid-operation SHALL discard all history.
REQ-017 After rstn release, each channel SHALL re-acquire from its first observed rise.

Verification
REQ-018 Reset: hold rstn=0 with the inputs toggling -> locked=0, err=000, meas_div10=0 throughout.
REQ-019 Nominal: drive periods 2/4/10 from rstn release -> locked=1 no earlier than 40 and no later than 50 clk cycles after release; err=000; meas_div10=10.
REQ-020 Period error: once locked, stretch one clk_div4 high phase by 1 cycle (period 5) -> err=3'b010 and locked=0 two clk after the late rise. With nominal periods resumed, locked=1 again after 4 good periods while err stays 3'b010.
REQ-021 Stuck input: once locked, hold clk_div10=0 for 25 cycles -> err[2]=1 when cnt reaches 20; channel 2 returns to ACQ; locked=0. When toggling resumes, the block relocks after 1 acquisition rise plus 4 good periods.
REQ-022 err_clr:
  - err_clr=1 with err=3'b110 and no event -> err=000 next cycle.
  - err_clr on the same cycle as a channel-0 bad period -> err=3'b001.
REQ-023 Reset mid-lock: assert rstn=0 for 3 cycles while locked -> locked=0 and meas_div10=0 immediately; the nominal relock sequence from REQ-019 is repeated.
